// File: rtl/serial_sub8.sv
// Bit-serial 8-bit subtractor (a - b), LSB first, start/busy/done handshake.
// Define SUB8_SATURATE_EN to clamp diff_out to 8'h00 on a final borrow.
module serial_sub8 (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start,
    input  logic [7:0] a,
    input  logic [7:0] b,
    output logic [7:0] diff_out,
    output logic       b_out,
    output logic       busy,
    output logic       done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [7:0]  a_sh_q, a_sh_d;
    logic [7:0]  b_sh_q, b_sh_d;
    logic [7:0]  res_sh_q, res_sh_d;
    logic [7:0]  diff_q, diff_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        br_q, br_d;
    logic        bout_q, bout_d;

    logic        bit_diff;
    logic        br_next;
    logic [7:0]  res_next;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            a_sh_q   <= 8'h00;
            b_sh_q   <= 8'h00;
            res_sh_q <= 8'h00;
            diff_q   <= 8'h00;
            cnt_q    <= 3'd0;
            br_q     <= 1'b0;
            bout_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            res_sh_q <= res_sh_d;
            diff_q   <= diff_d;
            cnt_q    <= cnt_d;
            br_q     <= br_d;
            bout_q   <= bout_d;
        end
    end

    // Single-bit full subtractor on the current LSBs
    always_comb begin
        bit_diff = a_sh_q[0] ^ b_sh_q[0] ^ br_q;
        br_next  = (~a_sh_q[0] & b_sh_q[0])
                 | (~(a_sh_q[0] ^ b_sh_q[0]) & br_q);
        res_next = {bit_diff, res_sh_q[7:1]};
    end

    always_comb begin
        state_d  = state_q;
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        res_sh_d = res_sh_q;
        diff_d   = diff_q;
        cnt_d    = cnt_q;
        br_d     = br_q;
        bout_d   = bout_q;

        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    a_sh_d  = a;
                    b_sh_d  = b;
                    br_d    = 1'b0;
                    cnt_d   = 3'd0;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                res_sh_d = res_next;
                br_d     = br_next;
                a_sh_d   = {1'b0, a_sh_q[7:1]};
                b_sh_d   = {1'b0, b_sh_q[7:1]};
                cnt_d    = cnt_q + 3'd1;
                if (cnt_q == 3'd7) begin
`ifdef SUB8_SATURATE_EN
                    diff_d = br_next ? 8'h00 : res_next;
`else
                    diff_d = res_next;
`endif
                    bout_d  = br_next;
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign diff_out = diff_q;
    assign b_out    = bout_q;
    assign busy     = (state_q == RUN);
    assign done     = (state_q == DONE);

endmodule

// File: tb/tb_serial_sub8.sv
// Scoreboard bench for serial_sub8: stimulus pushes expected results,
// a negedge monitor pops and compares on every done pulse.
module tb_serial_sub8;

    logic       clk;
    logic       reset_n;
    logic       start;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] diff_out;
    logic       b_out;
    logic       busy;
    logic       done;

    int n_chk  = 0;
    int n_fail = 0;

    logic [8:0] exp_q[$];

    serial_sub8 dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .start    (start),
        .a        (a),
        .b        (b),
        .diff_out (diff_out),
        .b_out    (b_out),
        .busy     (busy),
        .done     (done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Reference: plain integer subtraction, {borrow, diff}
    function automatic logic [8:0] model(input logic [7:0] x,
                                         input logic [7:0] y);
        int dd;
        logic bo;
        logic [7:0] r;
        dd = int'(x) - int'(y);
        bo = (dd < 0);
        r  = 8'((dd < 0) ? dd + 256 : dd);
`ifdef SUB8_SATURATE_EN
        if (bo) r = 8'h00;
`endif
        return {bo, r};
    endfunction

    // Monitor: result on done, hold of previous result during RUN
    logic [8:0] prev_res = 9'h000;
    int         busy_len = 0;
    logic       prev_done = 1'b0;

    always @(negedge clk) begin
        if (!reset_n) begin
            prev_res  = 9'h000;
            busy_len  = 0;
            prev_done = 1'b0;
        end else begin
            if (busy) begin
                busy_len++;
                chk("hold_during_run", {b_out, diff_out}, prev_res);
            end else if (done) begin
                chk("done_single", prev_done, 1'b0);
                chk("busy_len", busy_len, 8);
                if (exp_q.size() == 0) begin
                    chk("spurious_done", 1'b1, 1'b0);
                end else begin
                    prev_res = exp_q.pop_front();
                    chk("result", {b_out, diff_out}, prev_res);
                end
                busy_len = 0;
            end else begin
                busy_len = 0;
            end
            prev_done = done;
        end
    end

    task automatic run_op(input logic [7:0] ia, input logic [7:0] ib,
                          input bit glitch, input bit rst4);
        bit seen;
        a     = ia;
        b     = ib;
        start = 1'b1;
        exp_q.push_back(model(ia, ib));
        @(negedge clk);
        start = 1'b0;
        a     = 8'($urandom);
        b     = 8'($urandom);
        chk("accepted", busy, 1'b1);
        if (rst4) begin
            repeat (3) @(negedge clk);
            #2 reset_n = 1'b0;
            #1;
            chk("rst_diff", diff_out, 8'h00);
            chk("rst_flags", {b_out, busy, done}, 3'b000);
            void'(exp_q.pop_back());
            @(negedge clk);
            #2 reset_n = 1'b1;
            repeat (12) begin
                @(negedge clk);
                chk("no_done_after_rst", done, 1'b0);
            end
            return;
        end
        if (glitch) begin
            @(negedge clk);
            start = 1'b1;
            a     = 8'h00;
            b     = 8'h00;
            @(negedge clk);
            start = 1'b0;
        end
        seen = 1'b0;
        for (int k = 0; k < 16 && !seen; k++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        chk("done_timeout", seen, 1'b1);
    endtask

    initial begin
        reset_n = 1'b0;
        start   = 1'b0;
        a       = 8'h00;
        b       = 8'h00;
        repeat (4) begin
            @(negedge clk);
            start = 1'($urandom);
            a     = 8'($urandom);
            b     = 8'($urandom);
            #1;
            chk("reset_out", {diff_out, b_out, busy, done}, 11'h000);
        end
        start = 1'b0;
        @(negedge clk);
        #2 reset_n = 1'b1;
        repeat (20) begin
            @(negedge clk);
            chk("idle_after_reset", {busy, done}, 2'b00);
        end

        run_op(8'h5A, 8'h3C, 1'b0, 1'b0);
        @(negedge clk);
        run_op(8'h10, 8'h20, 1'b0, 1'b0);
        run_op(8'hFF, 8'hFF, 1'b0, 1'b0);
        run_op(8'h00, 8'h01, 1'b0, 1'b0);
        run_op(8'hFF, 8'h00, 1'b0, 1'b0);
        @(negedge clk);
        run_op(8'h80, 8'h01, 1'b1, 1'b0);
        run_op(8'h09, 8'h04, 1'b0, 1'b0);
        run_op(8'h33, 8'h77, 1'b0, 1'b1);
        run_op(8'hC3, 8'h42, 1'b0, 1'b0);

        for (int i = 0; i < 40; i++) begin
            int gap;
            gap = int'($urandom_range(0, 3));
            repeat (gap) @(negedge clk);
            run_op(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)),
                   1'b0);
        end

        repeat (3) @(negedge clk);
        chk("queue_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
